adjacency_map_store: RTL and testbench



---
 rtl/adjacency_map_store_pkg.sv | 30 +++
 rtl/adjacency_map_store_sdp_ram.sv | 34 +++
 rtl/adjacency_map_store.sv | 193 +++++++++++++++++++
 tb/tb_adjacency_map_store.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adjacency_map_store_pkg.sv
// Shared types and sizing for the adjacency map edge store.
package adjacency_map_store_pkg;

    localparam int MAX_NODES  = 1024;
    localparam int NODE_WIDTH = $clog2(MAX_NODES);
    localparam int MAX_EDGES  = 2048;
    localparam int EDGE_WIDTH = $clog2(MAX_EDGES);
    localparam int CNT_WIDTH  = EDGE_WIDTH + 1;

    typedef logic [NODE_WIDTH-1:0] node_t;
    typedef logic [EDGE_WIDTH-1:0] edge_ptr_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

    // One CSR row descriptor: where a node's successor group starts and how long it is.
    typedef struct packed {
        edge_ptr_t start;
        cnt_t      count;
    } head_entry_t;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_READY  = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    // Write pointer value at which the edge memory is full.
    localparam cnt_t EDGE_LIMIT = cnt_t'(MAX_EDGES);

endpackage

// File: rtl/adjacency_map_store_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register holds its value while rd_en is low, which lets the
// reply path keep a beat stable during back-pressure without extra storage.
module sdp_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, updated only when enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adjacency_map_store.sv
// Edge-list store: loads source-grouped edges into a CSR-style memory, then
// answers successor-list queries beat by beat.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. query_ready is high only in READY; a reply beat stays
// stable (valid, data, last, no_edges_found) while reply_valid && !reply_ready.
module adjacency_map_store
    import adjacency_map_store_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  decoding_done,
    input  logic  edge_valid,
    input  logic  src_node_valid,
    input  node_t src_node,
    input  node_t dst_node,
    input  node_t node_idx_cnt,
    output logic  query_ready,
    input  logic  query_valid,
    input  node_t query_data,
    input  logic  reply_ready,
    output logic  reply_valid,
    output logic  reply_last,
    output node_t reply_data,
    output logic  reply_no_edges_found
);

    state_t         state;
    cnt_t           wp;
    edge_ptr_t      cur_start;
    cnt_t           cur_count;
    logic [MAX_NODES-1:0] has_edges;
    node_t          node_cnt;
    node_t          q_node;
    logic           q_in_range;
    logic           head_pending;
    edge_ptr_t      rd_ptr;
    cnt_t           remaining;

    logic           load_active;
    logic           new_src;
    logic           edge_ok;
    logic           head_wr_en;
    head_entry_t    head_wr_data;
    logic [$bits(head_entry_t)-1:0] head_rd_raw;
    head_entry_t    head_rd;
    logic           decide;
    logic           take_edges;
    logic           beat_hs;
    logic           edge_rd_en;
    edge_ptr_t      edge_rd_addr;
    node_t          edge_rd_data;

    assign head_rd = head_rd_raw;

    // Load-side write control and query-side read control.
    always_comb begin
        load_active  = (state == ST_LOAD);
        new_src      = load_active && src_node_valid;
        edge_ok      = load_active && edge_valid && (wp != EDGE_LIMIT);
        head_wr_en   = new_src || edge_ok;
        head_wr_data = '0;
        if (new_src) begin
            // A new group starts at the current write pointer; a same-cycle edge is its first member.
            head_wr_data.start = wp[EDGE_WIDTH-1:0];
            head_wr_data.count = edge_ok ? cnt_t'(1) : '0;
        end else begin
            head_wr_data.start = cur_start;
            head_wr_data.count = cur_count + cnt_t'(1);
        end

        decide       = (state == ST_LOOKUP) && !head_pending;
        take_edges   = q_in_range && has_edges[q_node] && (head_rd.count != '0);
        beat_hs      = reply_valid && reply_ready;
        edge_rd_en   = (decide && take_edges) ||
                       ((state == ST_STREAM) && beat_hs && !reply_last);
        edge_rd_addr = (state == ST_LOOKUP) ? head_rd.start : rd_ptr;
        reply_data   = (reply_valid && !reply_no_edges_found) ? edge_rd_data : '0;
    end

    sdp_ram #(
        .WIDTH ($bits(head_entry_t)),
        .DEPTH (MAX_NODES)
    ) u_head_ram (
        .clk     (clk),
        .wr_en   (head_wr_en),
        .wr_addr (src_node),
        .wr_data (head_wr_data),
        .rd_en   (1'b1),
        .rd_addr (q_node),
        .rd_data (head_rd_raw)
    );

    sdp_ram #(
        .WIDTH (NODE_WIDTH),
        .DEPTH (MAX_EDGES)
    ) u_edge_ram (
        .clk     (clk),
        .wr_en   (edge_ok),
        .wr_addr (wp[EDGE_WIDTH-1:0]),
        .wr_data (dst_node),
        .rd_en   (edge_rd_en),
        .rd_addr (edge_rd_addr),
        .rd_data (edge_rd_data)
    );

    // Main controller: load bookkeeping, query acceptance, lookup and beat streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_LOAD;
            wp                   <= '0;
            cur_start            <= '0;
            cur_count            <= '0;
            has_edges            <= '0;
            node_cnt             <= '0;
            q_node               <= '0;
            q_in_range           <= 1'b0;
            head_pending         <= 1'b0;
            rd_ptr               <= '0;
            remaining            <= '0;
            query_ready          <= 1'b0;
            reply_valid          <= 1'b0;
            reply_last           <= 1'b0;
            reply_no_edges_found <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (new_src) begin
                        cur_start           <= wp[EDGE_WIDTH-1:0];
                        cur_count           <= edge_ok ? cnt_t'(1) : '0;
                        has_edges[src_node] <= edge_ok;
                    end else if (edge_ok) begin
                        cur_count           <= cur_count + cnt_t'(1);
                        has_edges[src_node] <= 1'b1;
                    end
                    if (edge_ok) begin
                        wp <= wp + cnt_t'(1);
                    end
                    if (decoding_done) begin
                        node_cnt    <= node_idx_cnt;
                        query_ready <= 1'b1;
                        state       <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (query_valid && query_ready) begin
                        q_node       <= query_data;
                        q_in_range   <= (query_data < node_cnt);
                        head_pending <= 1'b1;
                        query_ready  <= 1'b0;
                        state        <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (head_pending) begin
                        // Head RAM is reading q_node this cycle.
                        head_pending <= 1'b0;
                    end else begin
                        reply_valid <= 1'b1;
                        state       <= ST_STREAM;
                        if (take_edges) begin
                            reply_no_edges_found <= 1'b0;
                            reply_last           <= (head_rd.count == cnt_t'(1));
                            remaining            <= head_rd.count - cnt_t'(1);
                            rd_ptr               <= head_rd.start + edge_ptr_t'(1);
                        end else begin
                            reply_no_edges_found <= 1'b1;
                            reply_last           <= 1'b1;
                            remaining            <= '0;
                        end
                    end
                end
                ST_STREAM: begin
                    if (beat_hs) begin
                        if (reply_last) begin
                            reply_valid          <= 1'b0;
                            reply_last           <= 1'b0;
                            reply_no_edges_found <= 1'b0;
                            query_ready          <= 1'b1;
                            state                <= ST_READY;
                        end else begin
                            rd_ptr     <= rd_ptr + edge_ptr_t'(1);
                            remaining  <= remaining - cnt_t'(1);
                            reply_last <= (remaining == cnt_t'(1));
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_adjacency_map_store.sv
// Directed bench for adjacency_map_store with a queue-based reply scoreboard.
module tb_adjacency_map_store;
    import adjacency_map_store_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  decoding_done;
    logic  edge_valid;
    logic  src_node_valid;
    node_t src_node;
    node_t dst_node;
    node_t node_idx_cnt;
    logic  query_ready;
    logic  query_valid;
    node_t query_data;
    logic  reply_ready;
    logic  reply_valid;
    logic  reply_last;
    node_t reply_data;
    logic  reply_no_edges_found;

    // Expected beat packing: {no_edges_found, last, data}.
    localparam int BW = NODE_WIDTH + 2;
    logic [BW-1:0] exp_q[$];

    int n_vec  = 0;
    int n_miss = 0;
    int rr_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: never ready

    adjacency_map_store dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .decoding_done        (decoding_done),
        .edge_valid           (edge_valid),
        .src_node_valid       (src_node_valid),
        .src_node             (src_node),
        .dst_node             (dst_node),
        .node_idx_cnt         (node_idx_cnt),
        .query_ready          (query_ready),
        .query_valid          (query_valid),
        .query_data           (query_data),
        .reply_ready          (reply_ready),
        .reply_valid          (reply_valid),
        .reply_last           (reply_last),
        .reply_data           (reply_data),
        .reply_no_edges_found (reply_no_edges_found)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, exp_q size %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Reply back-pressure driver.
    initial begin
        int idx;
        logic [3:0] pat;
        idx = 0;
        pat = 4'b1001;
        reply_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       reply_ready = 1'b1;
                1:       begin reply_ready = pat[3 - (idx % 4)]; idx++; end
                default: reply_ready = 1'b0;
            endcase
        end
    end

    function automatic logic [BW-1:0] beat(input logic no_e, input logic last, input node_t d);
        return {no_e, last, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard.
    logic          prev_hs, prev_last_hs, prev_stall;
    logic [BW-1:0] prev_beat;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hs      = 1'b0;
            prev_last_hs = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            if (prev_last_hs) begin
                check("ready_return", {30'd0, query_ready, reply_valid}, 32'h2);
            end else if (prev_hs) begin
                check("no_bubble", {31'd0, reply_valid}, 32'h1);
            end
            if (prev_stall) begin
                check("stall_hold", {reply_valid, reply_no_edges_found, reply_last, reply_data},
                      {1'b1, prev_beat});
            end
            if (reply_valid) begin
                check("busy_query_ready", {31'd0, query_ready}, 32'h0);
            end
            if (reply_valid && reply_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat",
                             beat(reply_no_edges_found, reply_last, reply_data));
                end else begin
                    check("beat", beat(reply_no_edges_found, reply_last, reply_data), exp_q.pop_front());
                end
            end
            prev_hs      = reply_valid && reply_ready;
            prev_last_hs = reply_valid && reply_ready && reply_last;
            prev_stall   = reply_valid && !reply_ready;
            prev_beat    = beat(reply_no_edges_found, reply_last, reply_data);
        end
    end

    // Driver tasks; inputs change 1ns after the rising edge.
    task automatic load_edge(input node_t src, input node_t dst, input logic new_src, input logic has_edge);
        src_node_valid = new_src;
        edge_valid     = has_edge;
        src_node       = src;
        dst_node       = dst;
        @(posedge clk);
        #1;
        src_node_valid = 1'b0;
        edge_valid     = 1'b0;
    endtask

    task automatic finish_load(input node_t cnt);
        decoding_done = 1'b1;
        node_idx_cnt  = cnt;
        @(posedge clk);
        #1;
        decoding_done = 1'b0;
        @(negedge clk);
        check("ready_after_done", {31'd0, query_ready}, 32'h1);
    endtask

    task automatic send_query(input node_t q);
        int n;
        @(posedge clk);
        #1;
        query_valid = 1'b1;
        query_data  = q;
        n = 0;
        @(negedge clk);
        while (!query_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!query_ready) begin
            check("query_accept_timeout", 32'd0, 32'd1);
            query_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            query_valid = 1'b0;
            n = 0;
            do begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end while (!reply_valid && n < 20);
            check("first_beat_latency", n, 32'd2);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_exp_q_empty", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Main sequence.
    initial begin
        rst_n          = 1'b0;
        decoding_done  = 1'b0;
        edge_valid     = 1'b0;
        src_node_valid = 1'b0;
        src_node       = '0;
        dst_node       = '0;
        node_idx_cnt   = '0;
        query_valid    = 1'b0;
        query_data     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {reply_data, query_ready, reply_valid, reply_last, reply_no_edges_found}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Query before decoding_done must not be accepted.
        query_valid = 1'b1;
        query_data  = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_query_in_load", {30'd0, query_ready, reply_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        query_valid = 1'b0;

        // Load: 3 -> {5,7,9}, 5 -> {7}, 7 declared with no edges.
        load_edge(3, 5, 1'b1, 1'b1);
        load_edge(3, 7, 1'b0, 1'b1);
        load_edge(3, 9, 1'b0, 1'b1);
        load_edge(5, 7, 1'b1, 1'b1);
        load_edge(7, 0, 1'b1, 1'b0);
        finish_load(10);

        rr_mode = 0;
        exp_q.push_back(beat(1'b0, 1'b0, 5));
        exp_q.push_back(beat(1'b0, 1'b0, 7));
        exp_q.push_back(beat(1'b0, 1'b1, 9));
        send_query(3);
        wait_drain();

        exp_q.push_back(beat(1'b1, 1'b1, 0));
        send_query(7);
        wait_drain();

        exp_q.push_back(beat(1'b1, 1'b1, 0));
        send_query(12);
        wait_drain();

        exp_q.push_back(beat(1'b0, 1'b1, 7));
        send_query(5);
        wait_drain();

        exp_q.push_back(beat(1'b1, 1'b1, 0));
        send_query(9);
        wait_drain();

        // Same query under stalls.
        rr_mode = 1;
        exp_q.push_back(beat(1'b0, 1'b0, 5));
        exp_q.push_back(beat(1'b0, 1'b0, 7));
        exp_q.push_back(beat(1'b0, 1'b1, 9));
        send_query(3);
        wait_drain();

        // Abort mid-stream with reset.
        rr_mode = 2;
        send_query(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_abort_valid", {31'd0, reply_valid}, 32'h0);
        exp_q.delete();
        rr_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("back_in_load", {30'd0, query_ready, reply_valid}, 32'h0);
        @(posedge clk);
        #1;

        // Reload a fresh graph and query it.
        load_edge(1, 2, 1'b1, 1'b1);
        finish_load(10);
        exp_q.push_back(beat(1'b0, 1'b1, 2));
        send_query(1);
        wait_drain();

        exp_q.push_back(beat(1'b1, 1'b1, 0));
        send_query(3);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
